csr_file: RTL and testbench

- Machine-mode CSR register file for the single-issue RV64 NPC core.
- Executes CSRRW/CSRRS/CSRRC, ecall trap entry and mret.
- Drives six architectural CSR values out on csr_0..csr_5; the simulator debug/difftest exporter consumes these.
- Sits in the execute/writeback stage, alongside the integer register file.

---
 rtl/csr_pkg.sv | 23 ++
 rtl/csr_alu.sv | 17 +
 rtl/csr_file.sv | 90 +++++++++
 tb/tb_csr_file.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, op encoding, export order and mstatus fields
package csr_pkg;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  typedef enum logic [1:0] {OP_NONE, OP_RW, OP_RS, OP_RC} csr_op_e;
  localparam int CSR_NUM = 6;
  typedef logic [2:0] csr_idx_t;
  localparam csr_idx_t IDX_MSTATUS  = 3'd0;
  localparam csr_idx_t IDX_MTVEC    = 3'd1;
  localparam csr_idx_t IDX_MEPC     = 3'd2;
  localparam csr_idx_t IDX_MCAUSE   = 3'd3;
  localparam csr_idx_t IDX_MSCRATCH = 3'd4;
  localparam csr_idx_t IDX_MCYCLE   = 3'd5;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int CAUSE_ECALL_M  = 11;
endpackage

// File: rtl/csr_alu.sv
// csr_alu: new CSR value and write enable for CSRRW/CSRRS/CSRRC
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] nv,
  output logic            we
);
  always_comb begin
    nv = op == OP_RS ? (old | wdata) : op == OP_RC ? (old & ~wdata) : wdata;
    we = (op == OP_RW) || (op != OP_NONE && |wdata);
  end
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with ecall/mret handling and free-running mcycle
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000a_0000_1800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            ecall_valid,
  input  logic [XLEN-1:0] ecall_pc,
  input  logic            mret_valid,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mret_target,
  output logic [XLEN-1:0] csr_0,
  output logic [XLEN-1:0] csr_1,
  output logic [XLEN-1:0] csr_2,
  output logic [XLEN-1:0] csr_3,
  output logic [XLEN-1:0] csr_4,
  output logic [XLEN-1:0] csr_5
);
  localparam logic [XLEN-1:0] MS_WMASK = (XLEN'(1) << MSTATUS_MIE) | (XLEN'(1) << MSTATUS_MPIE);
  logic [XLEN-1:0] r [CSR_NUM];
  logic [XLEN-1:0] nv, wval;
  csr_idx_t idx;
  logic mapped, alu_we, we;
  always_comb begin
    idx    = IDX_MSTATUS;
    mapped = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS:  idx = IDX_MSTATUS;
      ADDR_MTVEC:    idx = IDX_MTVEC;
      ADDR_MEPC:     idx = IDX_MEPC;
      ADDR_MCAUSE:   idx = IDX_MCAUSE;
      ADDR_MSCRATCH: idx = IDX_MSCRATCH;
      ADDR_MCYCLE:   idx = IDX_MCYCLE;
      default:       mapped = 1'b0;
    endcase
  end
  csr_alu #(.XLEN(XLEN)) u_alu (
    .op    (csr_op),
    .old   (csr_rdata),
    .wdata (csr_wdata),
    .nv    (nv),
    .we    (alu_we)
  );
  // mstatus keeps its reset image outside MIE/MPIE, which also pins MPP at 11
  always_comb begin
    csr_rdata   = mapped ? r[idx] : '0;
    csr_illegal = csr_valid & ~mapped;
    we          = csr_valid & mapped & alu_we & ~ecall_valid & ~mret_valid;
    wval        = idx == IDX_MSTATUS ? ((MSTATUS_RST & ~MS_WMASK) | (nv & MS_WMASK)) :
                  (idx == IDX_MTVEC || idx == IDX_MEPC) ? (nv & ~XLEN'(3)) : nv;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CSR_NUM; i++) r[i] <= '0;
      r[IDX_MSTATUS] <= MSTATUS_RST;
    end else begin
      r[IDX_MCYCLE] <= r[IDX_MCYCLE] + XLEN'(1);
      if (ecall_valid) begin
        r[IDX_MEPC]                 <= ecall_pc & ~XLEN'(3);
        r[IDX_MCAUSE]               <= XLEN'(CAUSE_ECALL_M);
        r[IDX_MSTATUS][MSTATUS_MPIE] <= r[IDX_MSTATUS][MSTATUS_MIE];
        r[IDX_MSTATUS][MSTATUS_MIE]  <= 1'b0;
      end else if (mret_valid) begin
        r[IDX_MSTATUS][MSTATUS_MIE]  <= r[IDX_MSTATUS][MSTATUS_MPIE];
        r[IDX_MSTATUS][MSTATUS_MPIE] <= 1'b1;
      end else if (we) begin
        r[idx] <= wval;
      end
    end
  end
  always_comb begin
    trap_target = r[IDX_MTVEC];
    mret_target = r[IDX_MEPC];
    csr_0       = r[IDX_MSTATUS];
    csr_1       = r[IDX_MTVEC];
    csr_2       = r[IDX_MEPC];
    csr_3       = r[IDX_MCAUSE];
    csr_4       = r[IDX_MSCRATCH];
    csr_5       = r[IDX_MCYCLE];
  end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed and random checks of csr_file against an architectural model
module tb_csr_file;
  localparam logic [63:0] MS_RST = 64'h0000_000a_0000_1800;
  logic clk = 1'b0;
  logic rst = 1'b1, csr_valid = 1'b0, csr_illegal, ecall_valid = 1'b0, mret_valid = 1'b0;
  logic [1:0] csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [63:0] csr_wdata = '0, csr_rdata, ecall_pc = '0, trap_target, mret_target;
  logic [63:0] csr_0, csr_1, csr_2, csr_3, csr_4, csr_5;
  logic [63:0] outs [6];
  logic [63:0] exp [6];
  logic mvalid = 1'b0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  csr_file dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .ecall_valid(ecall_valid), .ecall_pc(ecall_pc), .mret_valid(mret_valid),
    .trap_target(trap_target), .mret_target(mret_target),
    .csr_0(csr_0), .csr_1(csr_1), .csr_2(csr_2), .csr_3(csr_3), .csr_4(csr_4), .csr_5(csr_5)
  );
  assign outs[0] = csr_0;
  assign outs[1] = csr_1;
  assign outs[2] = csr_2;
  assign outs[3] = csr_3;
  assign outs[4] = csr_4;
  assign outs[5] = csr_5;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask
  function automatic int idx_of(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      12'h340: return 4;
      12'hB00: return 5;
      default: return -1;
    endcase
  endfunction
  task automatic cyc(input logic r, input logic v, input logic [1:0] op, input logic [11:0] a,
                     input logic [63:0] wd, input logic e, input logic [63:0] pc, input logic m);
    int k;
    logic [63:0] nexp [6];
    logic [63:0] nv;
    rst = r; csr_valid = v; csr_op = op; csr_addr = a; csr_wdata = wd;
    ecall_valid = e; ecall_pc = pc; mret_valid = m;
    k = idx_of(a);
    #1;
    if (mvalid) begin
      check("rdata", csr_rdata, k >= 0 ? exp[k] : 64'h0);
      check("illegal", 64'(csr_illegal), 64'(v && k < 0));
      check("trap_target", trap_target, exp[1]);
      check("mret_target", mret_target, exp[2]);
    end
    nexp = exp;
    nexp[5] = exp[5] + 64'd1;
    if (r) begin
      foreach (nexp[i]) nexp[i] = '0;
      nexp[0] = MS_RST;
    end else if (e) begin
      nexp[2] = pc & ~64'h3;
      nexp[3] = 64'd11;
      nexp[0][7] = exp[0][3];
      nexp[0][3] = 1'b0;
    end else if (m) begin
      nexp[0][3] = exp[0][7];
      nexp[0][7] = 1'b1;
    end else if (v && k >= 0 && (op == 2'b01 || (op != 2'b00 && wd != 0))) begin
      nv = op == 2'b01 ? wd : op == 2'b10 ? (exp[k] | wd) : (exp[k] & ~wd);
      if (k == 0) nv = MS_RST | (nv & 64'h88);
      else if (k == 1 || k == 2) nv = nv & ~64'h3;
      nexp[k] = nv;
    end
    @(posedge clk);
    #1;
    exp = nexp;
    mvalid = 1'b1;
    for (int i = 0; i < 6; i++) check($sformatf("csr_%0d", i), outs[i], exp[i]);
    @(negedge clk);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask
  task automatic op_cyc(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd);
    cyc(1'b0, 1'b1, op, a, wd, 1'b0, 64'h0, 1'b0);
  endtask
  initial begin
    logic [11:0] addrs [8];
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'h7C0, 12'h301};
    cyc(1'b1, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, 1'b1, 2'b01, 12'h340, 64'h55, 1'b1, 64'h44, 1'b0);
    check("rst_mstatus", csr_0, 64'ha_0000_1800);
    check("rst_mscratch", csr_4, 64'h0);
    check("rst_mcycle", csr_5, 64'h0);
    for (int i = 1; i <= 3; i++) begin
      idle();
      check("mcycle_count", csr_5, 64'(i));
    end
    op_cyc(2'b01, 12'h340, 64'hDEAD);
    check("rw_mscratch", csr_4, 64'hDEAD);
    op_cyc(2'b10, 12'h340, 64'hF0000);
    check("rs_mscratch", csr_4, 64'hFDEAD);
    op_cyc(2'b11, 12'h340, 64'hD);
    check("rc_mscratch", csr_4, 64'hFDEA0);
    op_cyc(2'b01, 12'h305, 64'h8000_0003);
    check("mtvec_mask", csr_1, 64'h8000_0000);
    op_cyc(2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mstatus_mask", csr_0, 64'ha_0000_1888);
    op_cyc(2'b10, 12'h300, 64'h8);
    cyc(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b1, 64'h8000_0104, 1'b0);
    check("ecall_mepc", csr_2, 64'h8000_0104);
    check("ecall_mcause", csr_3, 64'd11);
    check("ecall_mstatus", csr_0, 64'ha_0000_1880);
    check("ecall_trap_target", trap_target, 64'h8000_0000);
    cyc(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0, 64'h0, 1'b1);
    check("mret_mstatus", csr_0, 64'ha_0000_1888);
    check("mret_target", mret_target, 64'h8000_0104);
    op_cyc(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mcycle_load", csr_5, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    check("mcycle_wrap", csr_5, 64'h0);
    op_cyc(2'b10, 12'hB00, 64'h0);
    check("mcycle_rs0", csr_5, 64'h1);
    op_cyc(2'b01, 12'h7C0, 64'h1234);
    check("illegal_noeffect", csr_4, 64'hFDEA0);
    cyc(1'b0, 1'b1, 2'b01, 12'h340, 64'h1234, 1'b1, 64'h8000_0206, 1'b1);
    check("prio_mscratch", csr_4, 64'hFDEA0);
    check("prio_mepc", csr_2, 64'h8000_0204);
    for (int n = 0; n < 400; n++) begin
      logic [63:0] wd;
      wd = $urandom_range(0, 3) == 0 ? 64'h0 : {$urandom(), $urandom()};
      cyc($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          addrs[$urandom_range(0, 7)], wd, $urandom_range(0, 12) == 0,
          {$urandom(), $urandom()}, $urandom_range(0, 12) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
